// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports, two prioritised write ports,
// per-register pending scoreboard and a0 debug mirror. Optional forwarding: REGFILE_BYPASS_EN.
module reg_file_mp #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 3,
    parameter int DBG_REG    = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RD*ADD_WIDTH-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]               rd_ready,
    input  logic                            wr0_en,
    input  logic [ADD_WIDTH-1:0]            wr0_addr,
    input  logic [DATA_WIDTH-1:0]           wr0_data,
    input  logic                            wr1_en,
    input  logic [ADD_WIDTH-1:0]            wr1_addr,
    input  logic [DATA_WIDTH-1:0]           wr1_data,
    input  logic                            rsv_en,
    input  logic [ADD_WIDTH-1:0]            rsv_addr,
    output logic [DATA_WIDTH-1:0]           a0,
    output logic [(1<<ADD_WIDTH)-1:0]       pending
);

    localparam int NREG = 1 << ADD_WIDTH;
    // One lookup per read port plus one extra for the a0 mirror.
    localparam int NLK  = NUM_RD + 1;

    logic [DATA_WIDTH-1:0] regs_reg  [NREG];
    logic [DATA_WIDTH-1:0] regs_next [NREG];
    logic [NREG-1:0]       pending_reg;
    logic [NREG-1:0]       pending_next;
    logic [NREG-1:0]       wr0_hit;
    logic [NREG-1:0]       wr1_hit;
    logic [NREG-1:0]       rsv_hit;

    // Per-register decode; register 0 never matches, so it can never be written or reserved.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wr0_hit[gi] = 1'b0;
                assign wr1_hit[gi] = 1'b0;
                assign rsv_hit[gi] = 1'b0;
            end else begin : g_nz
                assign wr0_hit[gi] = wr0_en && (wr0_addr == ADD_WIDTH'(gi));
                assign wr1_hit[gi] = wr1_en && (wr1_addr == ADD_WIDTH'(gi));
                assign rsv_hit[gi] = rsv_en && (rsv_addr == ADD_WIDTH'(gi));
            end

            assign regs_next[gi] = wr1_hit[gi] ? wr1_data :
                                   wr0_hit[gi] ? wr0_data : regs_reg[gi];

            // Reserve beats a same-cycle write so a fresh in-flight result stays tracked.
            assign pending_next[gi] = rsv_hit[gi] ? 1'b1 :
                                      (wr0_hit[gi] || wr1_hit[gi]) ? 1'b0 : pending_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_reg[r] <= '0;
            end
            pending_reg <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_reg[r] <= regs_next[r];
            end
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;

    generate
        for (gi = 0; gi < NLK; gi++) begin : g_lk
            logic [ADD_WIDTH-1:0]  addr;
            logic [DATA_WIDTH-1:0] data_sel;
            logic [DATA_WIDTH-1:0] data_reg;

            if (gi < NUM_RD) begin : g_addr_port
                assign addr = rd_addr[gi*ADD_WIDTH +: ADD_WIDTH];
            end else begin : g_addr_dbg
                assign addr = ADD_WIDTH'(DBG_REG);
            end

            always_comb begin
                data_sel = regs_reg[addr];
                if (addr == '0) begin
                    data_sel = '0;
                end
`ifdef REGFILE_BYPASS_EN
                if (wr1_hit[addr]) begin
                    data_sel = wr1_data;
                end else if (wr0_hit[addr]) begin
                    data_sel = wr0_data;
                end
`endif
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else begin
                    data_reg <= data_sel;
                end
            end

            if (gi < NUM_RD) begin : g_port
                logic ready_sel;
                logic ready_reg;

                always_comb begin
                    ready_sel = !pending_reg[addr];
`ifdef REGFILE_BYPASS_EN
                    // A forwarded value is usable unless the same address is re-reserved now.
                    if (wr1_hit[addr] || wr0_hit[addr]) begin
                        ready_sel = !rsv_hit[addr];
                    end
`endif
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        ready_reg <= 1'b1;
                    end else begin
                        ready_reg <= ready_sel;
                    end
                end

                assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
                assign rd_ready[gi]                         = ready_reg;
            end else begin : g_dbg
                assign a0 = data_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus pushes expectations tagged with the cycle at
// which the DUT output is due; a negedge monitor pops and compares them.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_ready;
    logic        wr0_en, wr1_en, rsv_en;
    logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [31:0] a0;
    logic [31:0] pending;

    reg_file_mp #(.ADD_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(3), .DBG_REG(10)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .a0(a0), .pending(pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 read port, 1 a0, 2 pending vector
        int          port;
        logic [31:0] data;
        logic        rdy;
        int          due;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic push(input int kind, input int port, input logic [31:0] d,
                        input logic r, input string n);
        exp_t e;
        e.kind = kind; e.port = port; e.data = d; e.rdy = r; e.due = cyc + 1; e.name = n;
        q.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [31:0] d, input logic r, input string n);
        push(0, p, d, r, n);
    endtask

    task automatic exp_a0(input logic [31:0] d, input string n);
        push(1, 0, d, 1'b1, n);
    endtask

    task automatic exp_pend(input logic [31:0] v, input string n);
        push(2, 0, v, 1'b1, n);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [31:0] got_d;
            logic        got_r;
            e = q.pop_front();
            got_r = 1'b1;
            case (e.kind)
                0: begin
                    got_d = rd_data[e.port*32 +: 32];
                    got_r = rd_ready[e.port];
                end
                1: got_d = a0;
                default: got_d = pending;
            endcase
            checks++;
            if (e.due != cyc || got_d !== e.data || got_r !== e.rdy) begin
                failures++;
                $display("FAIL %s: got data=%h ready=%b (cycle %0d), expected data=%h ready=%b (cycle %0d)",
                         e.name, got_d, got_r, cyc, e.data, e.rdy, e.due);
            end else begin
                $display("ok   %s: data=%h ready=%b", e.name, got_d, got_r);
            end
        end
    end

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    endtask

    initial begin
        logic [4:0]  a;
        logic [31:0] exp_v;
        logic        exp_r;

        rst = 1'b1; rd_addr = '0;
        wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
        wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
        wr0_data = '0; wr1_data = '0;
        step();

        // Random traffic, then a reset cycle carrying writes and a reserve.
        for (int i = 0; i < 6; i++) begin
            wr0_en = 1'b1; wr0_addr = 5'($urandom_range(1, 31)); wr0_data = $urandom;
            wr1_en = 1'b1; wr1_addr = 5'($urandom_range(1, 31)); wr1_data = $urandom;
            rsv_en = 1'b1; rsv_addr = 5'($urandom_range(1, 31));
            step();
        end
        rst = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'hCAFE0005;
        rsv_en = 1'b1; rsv_addr = 5'd7;
        set_rd(0, 5); set_rd(1, 7); set_rd(2, 10);
        for (int p = 0; p < 3; p++) exp_rd(p, 32'h0, 1'b1, "reset_rd");
        exp_a0(32'h0, "reset_a0");
        exp_pend(32'h0, "reset_pending");
        step();

        for (int k = 0; k < 11; k++) begin
            for (int p = 0; p < 3; p++) begin
                a = (3*k + p + 1 > 31) ? 5'd0 : 5'(3*k + p + 1);
                set_rd(p, a);
                exp_rd(p, 32'h0, 1'b1, "post_reset_zero");
            end
            step();
        end

        // Basic write then read on port 2.
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        step();
        set_rd(2, 5);
        exp_rd(2, 32'hDEADBEEF, 1'b1, "basic_x5");
        step();

        // Priority on x7, independent writes to x8/x9, x0 writes and reserve discarded.
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
        step();
        wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h00000088;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h00000055;
        set_rd(0, 7);
        exp_rd(0, 32'h22222222, 1'b1, "prio_x7");
        step();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        set_rd(1, 8); set_rd(2, 9);
        exp_rd(1, 32'h00000088, 1'b1, "both_ports_x8");
        exp_rd(2, 32'h00000055, 1'b1, "both_ports_x9");
        step();
        set_rd(0, 0);
        exp_rd(0, 32'h0, 1'b1, "x0_write_discard");
        exp_pend(32'h0, "x0_reserve_ignored");
        step();

        // Scoreboard sequence on x12.
        rsv_en = 1'b1; rsv_addr = 5'd12;
        step();
        set_rd(0, 12);
        exp_rd(0, 32'h0, 1'b0, "rsv_x12_not_ready");
        exp_pend(32'h00001000, "rsv_x12_pending");
        step();
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h5;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        set_rd(1, 12);
`ifdef REGFILE_BYPASS_EN
        exp_rd(1, 32'h5, 1'b0, "wr_rsv_x12_rd");
`else
        exp_rd(1, 32'h0, 1'b0, "wr_rsv_x12_rd");
`endif
        exp_pend(32'h00001000, "wr_rsv_x12_still_pending");
        step();
        wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'h6;
        set_rd(0, 12);
`ifdef REGFILE_BYPASS_EN
        exp_rd(0, 32'h6, 1'b1, "wr_only_x12_rd");
`else
        exp_rd(0, 32'h5, 1'b0, "wr_only_x12_rd");
`endif
        exp_pend(32'h0, "wr_only_x12_cleared");
        step();
        set_rd(2, 12);
        exp_rd(2, 32'h6, 1'b1, "x12_final");
        step();

        // Read-during-write on x3, and the a0 mirror of x10.
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA;
        step();
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'hB;
        set_rd(0, 3);
`ifdef REGFILE_BYPASS_EN
        exp_rd(0, 32'hB, 1'b1, "rdw_x3");
`else
        exp_rd(0, 32'hA, 1'b1, "rdw_x3");
`endif
        step();
        set_rd(0, 3);
        exp_rd(0, 32'hB, 1'b1, "x3_after");
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h42;
`ifdef REGFILE_BYPASS_EN
        exp_a0(32'h42, "a0_same_cycle");
`else
        exp_a0(32'h0, "a0_same_cycle");
`endif
        step();
        exp_a0(32'h42, "a0_next_cycle");
        step();

        // Reset mid-operation, with x13 left pending beforehand.
        rsv_en = 1'b1; rsv_addr = 5'd13;
        step();
        exp_pend(32'h00002000, "x13_pending");
        step();
        rst = 1'b1;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        set_rd(1, 9);
        exp_rd(1, 32'h0, 1'b1, "mid_reset_rd");
        exp_pend(32'h0, "mid_reset_pending");
        step();
        set_rd(1, 9);
        exp_v = 32'h0; exp_r = 1'b1;
        exp_rd(1, exp_v, exp_r, "x9_after_reset");
        set_rd(0, 10);
        exp_rd(0, 32'h0, 1'b1, "x10_after_reset");
        step();

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the next CPU revision, replacing the single-write, two-read register file. It has NUM_RD registered read ports and two write ports with fixed priority. A per-register pending scoreboard lets the pipeline track in-flight multi-cycle results, such as loads. Register 0 is hard-wired to zero, and a debug/test output mirrors register DBG_REG (a0 by default).

Parameters:
ADD_WIDTH, 5, address width; the file holds 2**ADD_WIDTH registers
DATA_WIDTH, 32, register width in bits
NUM_RD, 3, number of read ports (1..4)
DBG_REG, 10, index mirrored on a0

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
rd_addr  in  NUM_RD*ADD_WIDTH  read addresses; port i at bits [i*ADD_WIDTH +: ADD_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  registered read data, same packing
rd_ready  out  NUM_RD  registered; 1 = the register read was not pending
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADD_WIDTH  write port 0 address
wr0_data  in  DATA_WIDTH  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_addr  in  ADD_WIDTH  write port 1 address
wr1_data  in  DATA_WIDTH  write port 1 data
rsv_en  in  1  reserve request: mark rsv_addr pending
rsv_addr  in  ADD_WIDTH  register to reserve
a0  out  DATA_WIDTH  registered copy of register DBG_REG
pending  out  2**ADD_WIDTH  current scoreboard bits, for debug/hazard unit

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. All state updates on posedge clk.
- Reset, in one cycle:
  - all registers cleared to 0;
  - pending cleared to all-zero;
  - rd_data = 0, rd_ready = all-ones, a0 = 0.
  - Write and reserve inputs are ignored during the reset cycle.
- Read latency is 1 cycle. At each edge, rd_data[i] <= the value of register rd_addr[i].
- rd_ready[i] <= !pending[rd_addr[i]], using pending before this edge's update.
- Address 0 behaviour:
  - a read of address 0 returns 0 with rd_ready = 1;
  - writes to address 0 are discarded;
  - reserves of address 0 are ignored.
- Writes:
  - wrX_en with a nonzero address stores wrX_data at the edge.
  - If both ports target the same nonzero address in one cycle, wr1 wins and wr0 is dropped.
- Read-during-write to the same address, same cycle: without the feature, rd_data returns the old value.
- Scoreboard:
  - rsv_en sets pending[rsv_addr].
  - Any enabled write to address A clears pending[A].
  - A write to a non-pending register is legal and leaves pending unchanged.
  - If reserve and write target the same address in the same cycle, reserve wins: the bit ends at 1.
  - Re-reserving an already pending register is legal; the bit stays 1.
- a0 <= register[DBG_REG] each cycle, with the same old/new rule as the read ports.
- Reset asserted mid-operation overrides all same-cycle writes and reserves.
- Storage is inferred as flops; no initial blocks are relied on.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If an enabled write (winning port after priority) targets nonzero rd_addr[i] in the same cycle, rd_data[i] gets the write data at that edge.
  - rd_ready[i] is 1 unless a same-cycle reserve also targets that address.
  - a0 forwards in the same way.
- Undefined: reads return the pre-edge register contents and rd_ready uses the pre-edge pending bit. No bypass logic is generated.

Test Plan:
1. Reset check: hold rst 1 cycle after random traffic -> all rd_data = 0, a0 = 0, pending = 0, rd_ready all 1; then reading registers 1..31 returns 0.
2. Basic write/read: wr0 to x5 = 0xDEADBEEF, next cycle read x5 on port 2 -> rd_data port2 = 0xDEADBEEF one cycle after address is applied, rd_ready = 1.
3. Priority: same cycle wr0 x7 = 0x11111111 and wr1 x7 = 0x22222222 -> x7 = 0x22222222; separately, write x0 = 0xFFFFFFFF then read x0 -> 0.
4. Scoreboard:
   - reserve x12, then read x12 -> rd_ready = 0;
   - next, write x12 = 0x5 with reserve x12 in the same cycle -> still pending;
   - next, write x12 = 0x6 only -> pending[12] = 0, read returns 0x6 with ready = 1.
5. Read-during-write on x3 (old 0xA, new 0xB) -> 0xA without REGFILE_BYPASS_EN, 0xB with it. A write of x10 = 0x42 makes a0 = 0x42 one cycle later (same cycle with bypass).
6. Reset mid-operation: assert rst in the same cycle as wr1 x9 = 0x99 and rsv x9 -> after the edge x9 = 0 and pending[9] = 0.
